// File: rtl/dbus_bridge_pkg.sv
// Shared definitions for the data-bus bridge: FSM encodings, common constants,
// and the width helper for the optional response watchdog.
package dbus_bridge_pkg;

  localparam int InstBusW = 32;
  localparam logic [InstBusW-1:0] ZeroWord = '0;
  localparam logic Enable  = 1'b1;
  localparam logic Disable = 1'b0;

  typedef enum logic [1:0] {
    DBUS_IDLE = 2'd0,
    DBUS_REQ  = 2'd1,
    DBUS_RESP = 2'd2,
    DBUS_DONE = 2'd3
  } dbus_state_t;

  // Watchdog counter width: enough to reach the limit, clamped to 8..16 bits.
  function automatic int tmo_width(input int cyc);
    int w;
    w = $clog2(cyc + 1);
    if (w < 8) w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

endpackage

// File: rtl/dbus_timeout.sv
// Response watchdog for dbus_bridge; only built with DBUS_BRIDGE_TIMEOUT_EN.
// hit is high in the TIMEOUT_CYC-th counted cycle since the last clear.
`ifdef DBUS_BRIDGE_TIMEOUT_EN
module dbus_timeout
  import dbus_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic count_en,
  output logic hit
);

  localparam int CntW = tmo_width(TIMEOUT_CYC);

  logic [CntW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count_en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = count_en && (cnt == CntW'(TIMEOUT_CYC - 1));

endmodule
`endif

// File: rtl/dbus_bridge.sv
// Converts the flat load/store request into a valid/ready request + response
// channel, stalling the pipeline until completion. Watchdog: DBUS_BRIDGE_TIMEOUT_EN.
module dbus_bridge
  import dbus_bridge_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = InstBusW,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [3:0]        wen,
  input  logic              ren,
  output logic [DATA_W-1:0] r_data,
  output logic              stall,
  output logic              err,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  output logic [3:0]        req_wstrb,
  output logic              req_we,
  input  logic              resp_valid,
  output logic              resp_ready,
  input  logic [DATA_W-1:0] resp_rdata,
  input  logic              resp_err,
  output logic [1:0]        dbg_state
);

  // Handshakes: a request transfers on a cycle with req_valid && req_ready,
  // a response on resp_valid && resp_ready; each side holds its payload
  // stable until that cycle, and neither side waits on the other's flag.

  dbus_state_t state, state_nxt;

  logic       active;
  logic       req_hs;
  logic       resp_hs;
  logic       tmo_hit;
  logic       tmo_fire;
  logic [1:0] unused_addr_lsb;

  assign active          = ren | (|wen);
  assign req_hs          = (state == DBUS_REQ) && req_ready;
  assign resp_hs         = (state == DBUS_RESP) && resp_valid;
  assign tmo_fire        = tmo_hit && !req_hs && !resp_hs;
  assign unused_addr_lsb = addr[1:0];
  assign dbg_state       = state;

`ifdef DBUS_BRIDGE_TIMEOUT_EN
  dbus_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk      (clk),
    .rstn     (rstn),
    .clear    ((state == DBUS_IDLE) && active),
    .count_en ((state == DBUS_REQ) || (state == DBUS_RESP)),
    .hit      (tmo_hit)
  );
`else
  localparam int unused_tmo_cyc = TIMEOUT_CYC;
  assign tmo_hit = Disable;
`endif

  always_comb begin
    state_nxt  = state;
    stall      = Disable;
    req_valid  = Disable;
    resp_ready = Disable;
    case (state)
      DBUS_IDLE: begin
        // Gated by rstn so every output reads 0 while reset is held.
        stall = active & rstn;
        if (active) state_nxt = DBUS_REQ;
      end
      DBUS_REQ: begin
        req_valid = Enable;
        stall     = Enable;
        if (req_ready)     state_nxt = DBUS_RESP;
        else if (tmo_fire) state_nxt = DBUS_DONE;
      end
      DBUS_RESP: begin
        resp_ready = Enable;
        stall      = Enable;
        if (resp_valid || tmo_fire) state_nxt = DBUS_DONE;
      end
      // The request still on the inputs here is the retiring one; never reissue.
      DBUS_DONE: state_nxt = DBUS_IDLE;
      default:   state_nxt = DBUS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= DBUS_IDLE;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
      req_we    <= Disable;
      r_data    <= ZeroWord;
      err       <= Disable;
    end else begin
      state <= state_nxt;
      err   <= Disable;
      if ((state == DBUS_IDLE) && active) begin
        // A write wins over a simultaneous read; the strobes carry the kind.
        req_addr  <= {addr[ADDR_W-1:2], 2'b00};
        req_wdata <= w_data;
        req_wstrb <= wen;
        req_we    <= |wen;
      end
      if (resp_hs) begin
        if (resp_err) err <= Enable;
        if (!req_we)  r_data <= resp_err ? ZeroWord : resp_rdata;
      end else if (tmo_fire) begin
        err <= Enable;
        if (!req_we) r_data <= ZeroWord;
      end
    end
  end

endmodule

// File: doc/dbus_bridge.md
Name: dbus_bridge

Overview:
- Sits directly downstream of the load/store byte-lane interface and replaces the ideal zero-wait RAM on the data side.
- Takes the flat addr / w_data / wen / ren request and converts it into a registered valid/ready request channel plus a response channel toward RAM, peripherals or an interconnect.
- Holds the pipeline with stall until the transaction completes.
- Presents the read data registered and stable for the byte-lane decoder.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be 32 (4 byte strobes).
- TIMEOUT_CYC, 255, response watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- addr  in  ADDR_W  access address from byte-lane interface
- w_data  in  DATA_W  lane-aligned write data
- wen  in  4  byte write enables; any bit set = write
- ren  in  1  read request
- r_data  out  DATA_W  registered read data
- stall  out  1  pipeline hold
- err  out  1  one-cycle pulse, bus error/timeout
- req_valid  out  1  request valid
- req_ready  in  1  request accepted
- req_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- req_wdata  out  DATA_W  write data
- req_wstrb  out  4  byte strobes; 0 = read
- req_we  out  1  1 = write
- resp_valid  in  1  response valid
- resp_ready  out  1  response accepted
- resp_rdata  in  DATA_W  read data
- resp_err  in  1  slave error with response

Interface rule: reset rstn, asynchronous, active-low; clock clk.

Behaviour:
- Reset values: all outputs 0. State = IDLE, r_data = 0, request registers = 0.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - Access is active when ren or |wen.
  - stall = active (combinational).
  - On active: latch addr, w_data, wen, and the write flag (|wen) into request registers, then go to REQ.
- Write priority: if ren and |wen are both set, treat as a write and leave r_data unchanged.
- REQ:
  - req_valid = 1, stall = 1.
  - Request outputs hold stable until the req_valid && req_ready handshake.
  - On handshake, go to RESP. req_valid drops the next cycle.
- RESP:
  - resp_ready = 1, stall = 1.
  - On resp_valid, if it is a read, capture r_data <= resp_rdata.
  - On resp_valid with resp_err: pulse err for 1 cycle and force r_data = 0 for reads.
  - Then go to DONE.
- DONE:
  - stall = 0. The upstream request still present this cycle is the same instruction retiring, so it is ignored (no reissue).
  - Go to IDLE.
- Minimum latency with ready/valid both immediate: request at cycle 0, stall high for cycles 0-2, low in cycle 3.
- r_data is valid from the DONE cycle and holds until the next read response; the decoder samples it the cycle after retire.
- Writes also wait for a response (ordering guarantee); r_data is unchanged.
- req_ready high while not in REQ is ignored. resp_valid outside RESP is ignored; resp_ready = 0 there.
- Reset mid-transaction: immediate return to IDLE and all outputs 0. An outstanding bus transaction is abandoned; the slave is reset by the same rstn.
- Back-to-back accesses: a minimum 1 IDLE cycle between transactions.

Optional Feature:
- Macro: DBUS_BRIDGE_TIMEOUT_EN.
- With the macro:
  - An 8..16-bit counter, sized for TIMEOUT_CYC, clears on entry to REQ and counts every cycle in REQ or RESP.
  - On reaching TIMEOUT_CYC without the expected handshake: err pulses 1 cycle, r_data = 0 for reads, req_valid drops, go to DONE. A late resp_valid is later ignored.
- Without the macro: no counter; the bridge waits indefinitely. err comes only from resp_err.

Decomposition:
- Shared defines:
  - FSM state encodings (DBUS_IDLE/REQ/RESP/DONE, 2 bits).
  - The existing ZeroWord / Enable / Disable constants, and the InstBus width reused for data.
- Sub-module dbus_timeout (counter + compare, present only under the macro) is natural. Everything else stays in one module.

Test Plan:
- Read, zero-wait: ren=1, addr=0x100, req_ready=1 immediately, resp_valid in the next cycle with 0xCAFEBABE.
  - req_addr=0x100, req_wstrb=0.
  - stall high for 3 cycles; r_data=0xCAFEBABE in the DONE cycle and held afterwards.
- Byte write with wait states: wen=4'b0100, w_data=0x00AB0000, addr=0x202, req_ready delayed 3 cycles, resp delayed 2 cycles.
  - req_addr=0x200, req_wstrb=0100; outputs stable while stalled.
  - stall drops exactly 1 cycle after resp_valid; r_data unchanged.
- Simultaneous ren and wen=1111: transaction issued as a write with req_we=1; r_data unchanged.
- Error response: resp_err=1 on a read → err pulse of 1 cycle, r_data=0.
- Reset mid-transaction: rstn low while in RESP → all outputs 0 and the next request starts cleanly from IDLE.
- DBUS_BRIDGE_TIMEOUT_EN with TIMEOUT_CYC=8 and resp_valid never asserted → err pulses in the 8th wait cycle, stall releases, and a late resp_valid is ignored.
